// File: rtl/encoder_position_counter.sv
// Bounded position counter fed by the rotary-encoder direction FSM.
// Step levels are resynchronised, edge-detected, rate-limited by a holdoff window and counted.
module encoder_position_counter #(
   parameter int WIDTH    = 8,
   parameter int MIN_VAL  = 0,
   parameter int MAX_VAL  = 99,
   parameter int INIT_VAL = 0,
   parameter bit WRAP     = 1'b1,
   parameter int HOLDOFF  = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step_cw,
   input  logic             step_ccw,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] position,
   output logic             dir,
   output logic             step_pulse,
   output logic             wrap_pulse,
   output logic             limit_pulse,
   output logic             conflict_pulse,
   output logic             at_min,
   output logic             at_max
);

   localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [WIDTH-1:0] MIN_P  = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0] MAX_P  = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] INIT_P = WIDTH'(INIT_VAL);
   localparam logic [WIDTH-1:0] ONE_P  = WIDTH'(1);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF - 1);
   localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

   typedef enum logic {READY, HOLD} state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] count, count_next;
   logic [WIDTH-1:0] position_next;
   logic             dir_next;
   logic             step_next, wrap_next, limit_next, conflict_next;

   logic cw_sync1, cw_sync2, cw_hist;
   logic ccw_sync1, ccw_sync2, ccw_hist;
   logic cw_edge, ccw_edge;

   // Two-flop synchronisers plus a history flop so a held level yields one edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         cw_sync1  <= 1'b0;
         cw_sync2  <= 1'b0;
         cw_hist   <= 1'b0;
         ccw_sync1 <= 1'b0;
         ccw_sync2 <= 1'b0;
         ccw_hist  <= 1'b0;
      end else begin
         cw_sync1  <= step_cw;
         cw_sync2  <= cw_sync1;
         cw_hist   <= cw_sync2;
         ccw_sync1 <= step_ccw;
         ccw_sync2 <= ccw_sync1;
         ccw_hist  <= ccw_sync2;
      end
   end

   assign cw_edge  = cw_sync2 & ~cw_hist;
   assign ccw_edge = ccw_sync2 & ~ccw_hist;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= READY;
         count          <= '0;
         position       <= INIT_P;
         dir            <= 1'b0;
         step_pulse     <= 1'b0;
         wrap_pulse     <= 1'b0;
         limit_pulse    <= 1'b0;
         conflict_pulse <= 1'b0;
      end else begin
         state          <= state_next;
         count          <= count_next;
         position       <= position_next;
         dir            <= dir_next;
         step_pulse     <= step_next;
         wrap_pulse     <= wrap_next;
         limit_pulse    <= limit_next;
         conflict_pulse <= conflict_next;
      end
   end

   // Load swallows any coincident edge; otherwise READY accepts one step and arms the holdoff.
   always_comb begin
      state_next    = state;
      count_next    = count;
      position_next = position;
      dir_next      = dir;
      step_next     = 1'b0;
      wrap_next     = 1'b0;
      limit_next    = 1'b0;
      conflict_next = 1'b0;
      if (load) begin
         state_next = READY;
         count_next = '0;
         if (int'(load_value) < MIN_VAL)
            position_next = MIN_P;
         else if (load_value > MAX_P)
            position_next = MAX_P;
         else
            position_next = load_value;
      end else begin
         case (state)
            READY: begin
               if (cw_edge && ccw_edge) begin
                  conflict_next = 1'b1;
               end else if (cw_edge || ccw_edge) begin
                  step_next  = 1'b1;
                  dir_next   = cw_edge;
                  state_next = HOLD;
                  count_next = HOLD_LOAD;
                  if (cw_edge) begin
                     if (position == MAX_P) begin
                        if (WRAP) begin
                           position_next = MIN_P;
                           wrap_next     = 1'b1;
                        end else begin
                           limit_next = 1'b1;
                        end
                     end else begin
                        position_next = position + ONE_P;
                     end
                  end else begin
                     if (position == MIN_P) begin
                        if (WRAP) begin
                           position_next = MAX_P;
                           wrap_next     = 1'b1;
                        end else begin
                           limit_next = 1'b1;
                        end
                     end else begin
                        position_next = position - ONE_P;
                     end
                  end
               end
            end
            HOLD: begin
               if (count == '0)
                  state_next = READY;
               else
                  count_next = count - ONE_C;
            end
            default: state_next = READY;
         endcase
      end
   end

   assign at_min = (position == MIN_P);
   assign at_max = (position == MAX_P);

endmodule

// File: tb/tb_encoder_position_counter.sv
// Directed bench for encoder_position_counter: a wrapping instance with a long holdoff
// and a saturating instance with a short holdoff, checked against hand-computed values.
module tb_encoder_position_counter;

   localparam int WIDTH = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rstA = 1'b0, cwA = 1'b0, ccwA = 1'b0, loadA = 1'b0;
   logic [WIDTH-1:0] loadValueA = '0;
   logic [WIDTH-1:0] positionA;
   logic dirA, stepA, wrapA, limitA, conflictA, atMinA, atMaxA;

   logic             rstB = 1'b0, cwB = 1'b0, ccwB = 1'b0, loadB = 1'b0;
   logic [WIDTH-1:0] loadValueB = '0;
   logic [WIDTH-1:0] positionB;
   logic dirB, stepB, wrapB, limitB, conflictB, atMinB, atMaxB;

   int assertCount = 0;
   int failCount   = 0;

   encoder_position_counter #(
      .WIDTH(WIDTH), .MIN_VAL(0), .MAX_VAL(99), .INIT_VAL(0), .WRAP(1'b1), .HOLDOFF(1000)
   ) dutA (
      .clk(clk), .rst(rstA), .step_cw(cwA), .step_ccw(ccwA),
      .load(loadA), .load_value(loadValueA),
      .position(positionA), .dir(dirA), .step_pulse(stepA), .wrap_pulse(wrapA),
      .limit_pulse(limitA), .conflict_pulse(conflictA), .at_min(atMinA), .at_max(atMaxA)
   );

   encoder_position_counter #(
      .WIDTH(WIDTH), .MIN_VAL(0), .MAX_VAL(99), .INIT_VAL(0), .WRAP(1'b0), .HOLDOFF(4)
   ) dutB (
      .clk(clk), .rst(rstB), .step_cw(cwB), .step_ccw(ccwB),
      .load(loadB), .load_value(loadValueB),
      .position(positionB), .dir(dirB), .step_pulse(stepB), .wrap_pulse(wrapB),
      .limit_pulse(limitB), .conflict_pulse(conflictB), .at_min(atMinB), .at_max(atMaxB)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance n clocks, counting step pulses seen on instance A.
   task automatic applyStimulus(input int n, output int pulses);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (stepA) pulses++;
      end
   endtask

   int pulses;
   int expPos[5] = '{98, 99, 0, 1, 2};
   int expWrap[5] = '{0, 0, 1, 0, 0};

   initial begin
      // Reset both instances
      tick();
      rstA = 1'b1; rstB = 1'b1;
      tick();
      rstA = 1'b0; rstB = 1'b0;
      checkOutput("reset_pos", positionA, 0);
      checkOutput("reset_dir", dirA, 0);
      checkOutput("reset_step", stepA, 0);
      checkOutput("reset_at_min", atMinA, 1);
      checkOutput("reset_at_max", atMaxA, 0);

      // First CW step: two-edge latency, single pulse while held
      cwA = 1'b1;
      tick(); tick();
      checkOutput("lat_pos_early", positionA, 0);
      checkOutput("lat_step_early", stepA, 0);
      tick();
      checkOutput("first_pos", positionA, 1);
      checkOutput("first_step", stepA, 1);
      checkOutput("first_dir", dirA, 1);
      checkOutput("first_at_min", atMinA, 0);
      applyStimulus(47, pulses);
      checkOutput("held_extra_pulses", pulses, 0);
      cwA = 1'b0;
      applyStimulus(1000, pulses);

      // Five spaced CW steps from 97 through the wrap point
      loadA = 1'b1; loadValueA = 8'd97;
      tick();
      loadA = 1'b0;
      checkOutput("load_97", positionA, 97);
      for (int s = 0; s < 5; s++) begin
         cwA = 1'b1;
         tick(); tick(); tick();
         checkOutput("seq_pos", positionA, expPos[s]);
         checkOutput("seq_wrap", wrapA, expWrap[s]);
         checkOutput("seq_step", stepA, 1);
         if (s == 1) checkOutput("seq_at_max", atMaxA, 1);
         cwA = 1'b0;
         applyStimulus(1002, pulses);
      end

      // Holdoff: second step 10 cycles later ignored, third at cycle 1010 counted
      cwA = 1'b1;
      applyStimulus(3, pulses);
      checkOutput("ho_first_pos", positionA, 3);
      applyStimulus(2, pulses);
      cwA = 1'b0;
      applyStimulus(5, pulses);
      cwA = 1'b1;
      applyStimulus(5, pulses);
      checkOutput("ho_second_pulses", pulses, 0);
      checkOutput("ho_second_pos", positionA, 3);
      cwA = 1'b0;
      applyStimulus(995, pulses);
      cwA = 1'b1;
      applyStimulus(3, pulses);
      checkOutput("ho_third_pulses", pulses, 1);
      checkOutput("ho_third_pos", positionA, 4);
      cwA = 1'b0;
      applyStimulus(1002, pulses);

      // Coincident CW and CCW edges
      cwA = 1'b1; ccwA = 1'b1;
      tick(); tick(); tick();
      checkOutput("conf_pulse", conflictA, 1);
      checkOutput("conf_step", stepA, 0);
      checkOutput("conf_pos", positionA, 4);
      cwA = 1'b0; ccwA = 1'b0;
      tick();
      checkOutput("conf_pulse_clear", conflictA, 0);
      tick();
      cwA = 1'b1;
      tick(); tick(); tick();
      checkOutput("conf_ready_step", stepA, 1);
      checkOutput("conf_ready_pos", positionA, 5);
      cwA = 1'b0;
      applyStimulus(1002, pulses);

      // Load with coincident CW edge: clamp, no step
      cwA = 1'b1;
      tick(); tick();
      loadA = 1'b1; loadValueA = 8'd150;
      tick();
      loadA = 1'b0;
      checkOutput("load_clamp_pos", positionA, 99);
      checkOutput("load_no_step", stepA, 0);
      checkOutput("load_at_max", atMaxA, 1);
      applyStimulus(3, pulses);
      checkOutput("load_edge_lost", pulses, 0);
      cwA = 1'b0;
      tick(); tick();

      // CCW step into holdoff, reset mid-holdoff, immediate step accepted
      ccwA = 1'b1;
      tick(); tick(); tick();
      checkOutput("ccw_pos", positionA, 98);
      checkOutput("ccw_dir", dirA, 0);
      ccwA = 1'b0;
      tick(); tick(); tick();
      rstA = 1'b1;
      tick();
      rstA = 1'b0;
      checkOutput("midrst_pos", positionA, 0);
      cwA = 1'b1;
      tick(); tick(); tick();
      checkOutput("post_rst_step", stepA, 1);
      checkOutput("post_rst_pos", positionA, 1);
      cwA = 1'b0;

      // Saturating instance: blocked steps at both limits
      ccwB = 1'b1;
      tick(); tick(); tick();
      checkOutput("sat_min_pos", positionB, 0);
      checkOutput("sat_min_limit", limitB, 1);
      checkOutput("sat_min_step", stepB, 1);
      checkOutput("sat_min_dir", dirB, 0);
      checkOutput("sat_min_wrap", wrapB, 0);
      ccwB = 1'b0;
      tick();
      checkOutput("sat_limit_clear", limitB, 0);
      for (int i = 0; i < 8; i++) tick();
      cwB = 1'b1;
      tick(); tick(); tick();
      checkOutput("sat_cw_pos", positionB, 1);
      checkOutput("sat_cw_limit", limitB, 0);
      checkOutput("sat_cw_dir", dirB, 1);
      cwB = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      loadB = 1'b1; loadValueB = 8'd250;
      tick();
      loadB = 1'b0;
      checkOutput("sat_load_clamp", positionB, 99);
      checkOutput("sat_at_max", atMaxB, 1);
      cwB = 1'b1;
      tick(); tick(); tick();
      checkOutput("sat_max_pos", positionB, 99);
      checkOutput("sat_max_limit", limitB, 1);
      checkOutput("sat_max_step", stepB, 1);
      cwB = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
